lc3_mem_arbiter: RTL and testbench
==================================

# lc3_mem_arbiter

Shares the single LC-3 program/data memory between two requesters: the CPU datapath (MAR/MDR path) and a debug/loader port used to preload or inspect memory while the CPU is held. It serialises requests into one memory transaction at a time, handles the memory's fixed read latency, and returns data and a one-cycle acknowledge to the requester that was granted.

## Interface
- ADDR_W, 16, address width of both ports and memory
- DATA_W, 16, data width
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle in which mem_rdata is valid (legal 1..4)

- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- cpu_req / dbg_req  in  1  request, held until matching ack
- cpu_we / dbg_we  in  1  1 = write, 0 = read; stable while req high
- cpu_addr / dbg_addr  in  ADDR_W  address; stable while req high
- cpu_wdata / dbg_wdata  in  DATA_W  write data; stable while req high
- cpu_rdata / dbg_rdata  out  DATA_W  registered read data, valid from ack cycle until the next read completes for that port
- cpu_ack / dbg_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  latched transaction address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high whenever state is not IDLE
- owner  out  1  0 = CPU, 1 = debug; meaningful while busy

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req high, choose grant per policy (see Configuration), latch addr/we/wdata and owner -> ISSUE; else stay.
- ISSUE: mem_en=1, mem_we=latched we, for exactly one cycle. Write -> DONE. Read -> WAIT, load counter with MEM_LAT.
- WAIT: counter decrements each cycle; in the cycle counter==1, mem_rdata is captured into the owner's rdata register -> DONE.
- DONE: owner's ack=1 for one cycle -> IDLE. Write leaves rdata unchanged.
- Only one transaction in flight; the non-granted request stays pending (req held) and is evaluated in the next IDLE cycle.
- Requester keeping req high after ack is a new back-to-back request, evaluated in the following IDLE cycle.
- req dropped before ack (protocol violation): transaction completes, ack still pulsed.
- mem_addr/mem_wdata hold last latched values when idle; mem_en/mem_we 0 outside ISSUE.

## Timing
- Reset values: state IDLE; busy, owner, mem_en, mem_we, cpu_ack, dbg_ack = 0; mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0; round-robin pointer = debug (so CPU wins first tie).
- Cycle 0 = IDLE cycle with req high. Write: mem_en cycle 1, ack cycle 2. Read: mem_en cycle 1, WAIT cycles 2..1+MEM_LAT, ack cycle 2+MEM_LAT.
- Back-to-back minimum period: read 3+MEM_LAT cycles, write 3 cycles.
- Reset asserted mid-transaction: immediate return to reset values, no ack; a write already strobed may have committed; a req still high after release is a fresh request.
- Ack and new req of the other port in the same cycle: other port granted in the next IDLE cycle.

## Configuration
- ARB_RR_EN defined: round-robin; on simultaneous requests grant goes to the port not granted most recently; pointer updates on each grant.
- ARB_RR_EN undefined: fixed priority, CPU always wins ties; debug port may starve while CPU requests continuously (intended: debug used with CPU halted).

## Test plan
- Reset=0 with random inputs -> every output 0, busy=0; release -> stays IDLE until a req.
- MEM_LAT=2, cpu_req read 0x0003, mem_rdata=0x5020 -> mem_en cycle 1 with mem_addr=0x0003, cpu_ack cycle 4, cpu_rdata=0x5020 held afterwards.
- dbg_req write 0x0010 data 0xABCD -> cycle 1 mem_en=mem_we=1, mem_addr=0x0010, mem_wdata=0xABCD; dbg_ack cycle 2; dbg_rdata unchanged.
- cpu_req and dbg_req reads held high for 4 grants -> without ARB_RR_EN order C,C,C,C (no dbg_ack); with ARB_RR_EN order C,D,C,D.
- CPU read with req held high -> acks cycles 4 and 9, second mem_en at cycle 6.
- Reset pulsed low during WAIT -> no ack, cpu_rdata=0; after release with req high, mem_en reissued one cycle after first IDLE cycle.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// Two-port arbiter sharing the LC-3 memory between the CPU datapath and a debug/loader port.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the CPU has fixed priority.
module lc3_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [2:0] cnt;
  logic       lat_we;
  logic       grant_dbg;

`ifdef ARB_RR_EN
  // Port granted most recently; resets to debug so the CPU wins the first tie.
  logic rr_last;

  always_comb begin
    grant_dbg = dbg_req && (!cpu_req || !rr_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (state == IDLE && (cpu_req || dbg_req)) begin
      rr_last <= grant_dbg;
    end
  end
`else
  always_comb begin
    grant_dbg = dbg_req && !cpu_req;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      owner     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            owner     <= grant_dbg;
            lat_we    <= grant_dbg ? dbg_we    : cpu_we;
            mem_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
            mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_we) begin
            state <= DONE;
          end else begin
            cnt   <= 3'(MEM_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          // mem_rdata is valid in the last WAIT cycle, MEM_LAT cycles after mem_en.
          if (cnt == 3'd1) begin
            if (owner) dbg_rdata <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
            state <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign mem_en  = (state == ISSUE);
  assign mem_we  = (state == ISSUE) && lat_we;
  assign cpu_ack = (state == DONE) && !owner;
  assign dbg_ack = (state == DONE) && owner;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed self-checking bench for lc3_mem_arbiter (MEM_LAT=2) with a latency-accurate memory model.
`timescale 1ns/1ps
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [15:0] dbg_addr = '0, dbg_wdata = '0;
  logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, dbg_ack, mem_en, mem_we, busy, owner;

  int checks = 0;
  int failures = 0;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Memory returns addr^0x5023 only in the cycle MEM_LAT after the read strobe.
  logic [2:0]  rd_pend = '0;
  logic [15:0] rd_addr = '0;
  always @(posedge clk) begin
    if (mem_en && !mem_we) begin
      rd_pend <= 3'd2;
      rd_addr <= mem_addr;
    end else if (rd_pend != 3'd0) begin
      rd_pend <= rd_pend - 3'd1;
    end
  end
  assign mem_rdata = (rd_pend == 3'd1) ? (rd_addr ^ 16'h5023) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic exp_order [4];
  logic got_order [4];
  int   n;

  initial begin
`ifdef ARB_RR_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
      dbg_req = 1'($urandom); dbg_we = 1'($urandom);
      dbg_addr = 16'($urandom); dbg_wdata = 16'($urandom);
      step();
    end
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_dbg_ack", dbg_ack, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    cpu_req = 0; dbg_req = 0;
    rst_n = 1'b1;
    step(); step(); step();
    check("idle_busy", busy, 0);
    check("idle_mem_en", mem_en, 0);

    // CPU read 0x0003
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003;
    check("rd_c0_busy", busy, 0);
    step();
    check("rd_c1_mem_en", mem_en, 1);
    check("rd_c1_mem_we", mem_we, 0);
    check("rd_c1_mem_addr", mem_addr, 16'h0003);
    check("rd_c1_owner", owner, 0);
    step();
    check("rd_c2_mem_en", mem_en, 0);
    check("rd_c2_ack", cpu_ack, 0);
    step();
    check("rd_c3_ack", cpu_ack, 0);
    step();
    check("rd_c4_ack", cpu_ack, 1);
    check("rd_c4_rdata", cpu_rdata, 16'h5020);
    cpu_req = 0;
    step();
    check("rd_c5_ack", cpu_ack, 0);
    check("rd_c5_busy", busy, 0);
    check("rd_c5_rdata_hold", cpu_rdata, 16'h5020);
    check("rd_c5_dbg_rdata", dbg_rdata, 0);

    // Debug write 0x0010 <- 0xABCD
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0010; dbg_wdata = 16'hABCD;
    step();
    check("wr_c1_mem_en", mem_en, 1);
    check("wr_c1_mem_we", mem_we, 1);
    check("wr_c1_mem_addr", mem_addr, 16'h0010);
    check("wr_c1_mem_wdata", mem_wdata, 16'hABCD);
    check("wr_c1_owner", owner, 1);
    step();
    check("wr_c2_dbg_ack", dbg_ack, 1);
    check("wr_c2_cpu_ack", cpu_ack, 0);
    check("wr_c2_dbg_rdata", dbg_rdata, 0);
    dbg_req = 0; dbg_we = 0;
    step();
    check("wr_c3_dbg_ack", dbg_ack, 0);
    check("wr_c3_busy", busy, 0);
    check("wr_c3_addr_hold", mem_addr, 16'h0010);
    check("wr_c3_wdata_hold", mem_wdata, 16'hABCD);
    check("wr_c3_cpu_rdata", cpu_rdata, 16'h5020);

    // Simultaneous held reads: four grants
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0030;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      step();
      if (cpu_ack || dbg_ack) begin
        got_order[n] = dbg_ack;
        if (dbg_ack) check("arb_dbg_rdata", dbg_rdata, 16'h5013);
        else         check("arb_cpu_rdata", cpu_rdata, 16'h5003);
        n++;
        if (n == 4) begin
          cpu_req = 0; dbg_req = 0;
        end
      end
    end
    cpu_req = 0; dbg_req = 0;
    check("arb_grant_count", n, 4);
    for (int k = 0; k < 4 && k < n; k++) begin
      check($sformatf("arb_order_%0d", k), got_order[k], exp_order[k]);
    end
    step(); step();
    check("arb_idle", busy, 0);

    // Back-to-back CPU reads with req held
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003;
    for (int c = 1; c <= 9; c++) begin
      step();
      check($sformatf("b2b_ack_c%0d", c), cpu_ack, (c == 4 || c == 9) ? 1 : 0);
      check($sformatf("b2b_en_c%0d", c), mem_en, (c == 1 || c == 6) ? 1 : 0);
    end
    cpu_req = 0;
    step();
    check("b2b_idle", busy, 0);

    // Reset during WAIT
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0007;
    step();
    step();
    check("rw_in_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rw_busy", busy, 0);
    check("rw_cpu_rdata", cpu_rdata, 0);
    check("rw_mem_addr", mem_addr, 0);
    step();
    check("rw_ack_in_reset", cpu_ack, 0);
    step();
    rst_n = 1'b1;
    check("rw_rel_mem_en", mem_en, 0);
    step();
    check("rw_reissue_en", mem_en, 1);
    check("rw_reissue_addr", mem_addr, 16'h0007);
    step(); step();
    check("rw_c3_ack", cpu_ack, 0);
    step();
    check("rw_c4_ack", cpu_ack, 1);
    check("rw_c4_rdata", cpu_rdata, 16'h5024);
    cpu_req = 0;
    step();
    check("rw_end_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
